// File: rtl/load_state_machine.sv
// Memory-to-register load controller: reads a burst of words from memory,
// one request/wait/write round per word, with a per-word stall timeout.
module load_state_machine #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int REG_W   = 4,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ldFlag,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [REG_W-1:0]  destReg,
  input  logic [CNT_W-1:0]  wordCount,
  input  logic              memReady,
  input  logic [DATA_W-1:0] memData,
  output logic              memRead,
  output logic [ADDR_W-1:0] memAddr,
  output logic              regIn,
  output logic [REG_W-1:0]  regAddr,
  output logic [DATA_W-1:0] regData,
  output logic              lwEnable,
  output logic              busy,
  output logic              loadEnd,
  output logic              loadErr
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [REG_W-1:0]  reg_idx_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TMO_W-1:0]  tmo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      reg_idx_q <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ldFlag) begin
            if (wordCount != '0) begin
              addr_q    <= baseAddr;
              reg_idx_q <= destReg;
              cnt_q     <= wordCount;
              state_q   <= S_REQ;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_REQ: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A ready on the last allowed stall cycle still wins over the timeout.
          if (memReady) begin
            data_q  <= memData;
            state_q <= S_WRITE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
              state_q <= S_ERR;
            end
          end
        end
        S_WRITE: begin
          addr_q    <= addr_q + 1'b1;
          reg_idx_q <= reg_idx_q + 1'b1;
          cnt_q     <= cnt_q - 1'b1;
          state_q   <= (cnt_q == CNT_W'(1)) ? S_DONE : S_REQ;
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Address/data buses are driven only while their strobe is active.
  assign memRead  = (state_q == S_REQ) || (state_q == S_WAIT);
  assign regIn    = (state_q == S_WRITE);
  assign lwEnable = memRead || regIn;
  assign busy     = (state_q != S_IDLE);
  assign loadEnd  = (state_q == S_DONE);
  assign loadErr  = (state_q == S_ERR);
  assign memAddr  = memRead ? addr_q : '0;
  assign regAddr  = regIn ? reg_idx_q : '0;
  assign regData  = regIn ? data_q : '0;

endmodule

// File: tb/tb_load_state_machine.sv
// Randomized scoreboard bench for load_state_machine: a burst-level model
// queues expected writes/end/error events and memory read plans.
module tb_load_state_machine;

  localparam int TIMEOUT = 15;
  localparam int EV_WR   = 1;
  localparam int EV_END  = 2;
  localparam int EV_ERR  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       ldFlag;
  logic [7:0] baseAddr;
  logic [3:0] destReg;
  logic [3:0] wordCount;
  logic       memReady;
  logic [7:0] memData;
  logic       memRead;
  logic [7:0] memAddr;
  logic       regIn;
  logic [3:0] regAddr;
  logic [7:0] regData;
  logic       lwEnable;
  logic       busy;
  logic       loadEnd;
  logic       loadErr;

  load_state_machine #(
    .ADDR_W(8), .DATA_W(8), .REG_W(4), .CNT_W(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .ldFlag(ldFlag), .baseAddr(baseAddr),
    .destReg(destReg), .wordCount(wordCount), .memReady(memReady),
    .memData(memData), .memRead(memRead), .memAddr(memAddr), .regIn(regIn),
    .regAddr(regAddr), .regData(regData), .lwEnable(lwEnable), .busy(busy),
    .loadEnd(loadEnd), .loadErr(loadErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int a;
    int d;
  } ev_t;

  typedef struct {
    int addr;
    int stall;
    int data;
  } plan_t;

  ev_t   exp_q[$];
  plan_t plan_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic void check(string nm, int act, int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endfunction

  // Memory responder: the first memRead cycle of each word is REQ; WAIT
  // cycle k (k>=1) returns data when k == stall+1.
  int    rk = 0;
  bit    rhave = 0;
  plan_t rcur;
  always @(negedge clk) begin
    if (reset || !memRead) begin
      rk       = 0;
      memReady = 1'b0;
      memData  = 8'($urandom);
    end else begin
      if (rk == 0) begin
        rhave = (plan_q.size() != 0);
        if (rhave) rcur = plan_q.pop_front();
      end
      if (rhave) check("mem_addr", int'(memAddr), rcur.addr);
      memReady = rhave && (rk >= 1) && (rk == rcur.stall + 1);
      memData  = memReady ? 8'(rcur.data) : 8'($urandom);
      rk++;
    end
  end

  // Monitor: pops an expectation for every regIn / loadEnd / loadErr cycle.
  ev_t mev;
  int  mkind;
  always @(negedge clk) begin
    if (regIn || loadEnd || loadErr) begin
      mkind = regIn ? EV_WR : (loadEnd ? EV_END : EV_ERR);
      if (exp_q.size() == 0) begin
        check("unexpected_event", mkind, 0);
      end else begin
        mev = exp_q.pop_front();
        check("event_kind", mkind, mev.kind);
        if (regIn) begin
          check("reg_addr", int'(regAddr), mev.a);
          check("reg_data", int'(regData), mev.d);
          $display("write reg=%0h data=%02h", regAddr, regData);
        end
      end
    end
    if (busy) begin
      check("lw_enable", int'(lwEnable), int'(memRead || regIn));
      check("one_hot_ctrl", $countones({memRead, regIn, loadEnd, loadErr}), 1);
    end else begin
      check("idle_outputs",
            int'({memRead, memAddr, regIn, regAddr, regData, lwEnable, loadEnd, loadErr}), 0);
    end
  end

  // Burst-level reference: each word costs REQ + (stall+1) WAIT + WRITE;
  // a stall of TIMEOUT or more ends the burst after TIMEOUT WAIT cycles.
  task automatic start_load(input int base, input int dest, input int cnt,
                            input int st[16], input int dat[16], output int exp_busy);
    int    n = 1;
    bit    err = 0;
    plan_t p;
    ev_t   e;
    baseAddr  = 8'(base);
    destReg   = 4'(dest);
    wordCount = 4'(cnt);
    ldFlag    = 1'b1;
    for (int i = 0; i < cnt && !err; i++) begin
      p.addr = (base + i) % 256;
      p.stall = st[i];
      p.data = dat[i];
      plan_q.push_back(p);
      if (st[i] < TIMEOUT) begin
        e.kind = EV_WR; e.a = (dest + i) % 16; e.d = dat[i];
        exp_q.push_back(e);
        n += 3 + st[i];
      end else begin
        err = 1;
        n += 1 + TIMEOUT;
      end
    end
    e.kind = err ? EV_ERR : EV_END; e.a = 0; e.d = 0;
    exp_q.push_back(e);
    exp_busy = n;
    $display("load base=%02h dest=%0h count=%0d expect_busy=%0d err=%0d",
             base, dest, cnt, n, err);
  endtask

  task automatic measure(input string nm, input int exp_busy, input bit hold);
    int n = 0;
    @(negedge clk);
    if (!hold) ldFlag = 1'b0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    check(nm, n, exp_busy);
  endtask

  int st[16];
  int dat[16];
  int eb;
  int r;
  int cnt;

  initial begin
    reset = 1'b1; ldFlag = 1'b0; baseAddr = '0; destReg = '0; wordCount = '0;
    memReady = 1'b0; memData = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          int'({busy, memRead, memAddr, regIn, regAddr, regData, lwEnable, loadEnd, loadErr}), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single word
    st[0] = 0; dat[0] = 'hA5;
    start_load('h10, 3, 1, st, dat, eb);
    measure("single_busy", eb, 0);
    check("single_expected_busy", eb, 4);

    // Burst with stalls 0/2/1
    st[0] = 0; st[1] = 2; st[2] = 1; dat[0] = 'h11; dat[1] = 'h22; dat[2] = 'h33;
    start_load('h20, 0, 3, st, dat, eb);
    measure("burst_busy", eb, 0);

    // Zero count
    start_load('h55, 7, 0, st, dat, eb);
    measure("zero_busy", eb, 0);

    // Timeout with memReady held low
    st[0] = 1000; st[1] = 0;
    start_load('h30, 2, 2, st, dat, eb);
    measure("timeout_busy", eb, 0);

    // Ready on the last allowed WAIT cycle succeeds; one later times out
    st[0] = TIMEOUT - 1; st[1] = TIMEOUT; dat[0] = 'h5A;
    start_load('h38, 9, 2, st, dat, eb);
    measure("edge_timeout_busy", eb, 0);

    // Reset during the second WAIT of a 4-word burst
    baseAddr = 'h40; destReg = 1; wordCount = 4; ldFlag = 1'b1;
    @(negedge clk); ldFlag = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_in_wait", int'(memRead && !regIn), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs",
          int'({busy, memRead, memAddr, regIn, regAddr, regData, lwEnable, loadEnd, loadErr}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_idle", int'(busy), 0);
    st[0] = 1; st[1] = 0; dat[0] = 'hC3; dat[1] = 'h3C;
    start_load('h80, 6, 2, st, dat, eb);
    measure("after_reset_busy", eb, 0);

    // Wrap-around with ldFlag held through the burst; restart after IDLE cycle
    st[0] = 0; st[1] = 0; dat[0] = 'hE1; dat[1] = 'hE2;
    start_load('hFF, 'hF, 2, st, dat, eb);
    measure("wrap_busy1", eb, 1);
    check("wrap_idle_gap", int'(busy), 0);
    dat[0] = 'hF1; dat[1] = 'hF2;
    start_load('hFF, 'hF, 2, st, dat, eb);
    measure("wrap_busy2", eb, 0);

    // Randomized bursts
    for (int t = 0; t < 30; t++) begin
      cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 19);
        if (r < 16)       st[i] = $urandom_range(0, 3);
        else if (r < 18)  st[i] = TIMEOUT - 1;
        else if (r == 18) st[i] = TIMEOUT;
        else              st[i] = $urandom_range(4, 10);
        dat[i] = $urandom_range(0, 255);
      end
      start_load($urandom_range(0, 255), $urandom_range(0, 15), cnt, st, dat, eb);
      measure("rand_busy", eb, 0);
    end

    repeat (3) @(negedge clk);
    check("events_left", exp_q.size(), 0);
    check("plans_left", plan_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
